// File: rtl/ucsbece154b_imem_arbiter.sv
// rtl/ucsbece154b_imem_arbiter.sv - fixed-priority imem burst arbiter (demand over prefetch, with merge)
module ucsbece154b_imem_arbiter #(
  parameter int BLOCK_WORDS = 4,
  parameter int WORD_SIZE   = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           dReq,
  input  logic [31:0]                    dAddr,
  output logic                           dAck,
  output logic                           dValid,
  output logic                           dDone,
  input  logic                           pReq,
  input  logic [31:0]                    pAddr,
  output logic                           pAck,
  output logic                           pValid,
  output logic                           pDone,
  output logic [WORD_SIZE-1:0]           rdData,
  output logic [$clog2(BLOCK_WORDS)-1:0] rdIndex,
  output logic                           memReadRequest,
  output logic [31:0]                    memReadAddress,
  input  logic [WORD_SIZE-1:0]           memDataIn,
  input  logic                           memDataReady,
  input  logic [$clog2(BLOCK_WORDS)-1:0] memBlockIndex
);

  localparam int OFF = $clog2(BLOCK_WORDS) + 2;
  localparam int CW  = $clog2(BLOCK_WORDS) + 1;
  localparam logic [31:0] BLK_MASK = ~((32'd1 << OFF) - 32'd1);
  localparam logic [CW-1:0] LAST_CNT = CW'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {IDLE, DEMAND, PREFETCH} state_t;

  state_t        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          merged_q, merged_d;
  logic          last_word;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      merged_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      merged_q <= merged_d;
    end
  end

  assign last_word      = memDataReady && (cnt_q == LAST_CNT);
  assign memReadRequest = (state_q != IDLE);
  assign memReadAddress = addr_q;
  assign rdData         = memDataIn;
  assign rdIndex        = memBlockIndex;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    merged_d = merged_q;
    dAck     = 1'b0;
    pAck     = 1'b0;
    dValid   = 1'b0;
    pValid   = 1'b0;
    dDone    = 1'b0;
    pDone    = 1'b0;
    // Acks are combinational on the requests, so they must be masked while reset is held.
    if (reset) begin
      case (state_q)
        IDLE: begin
          if (dReq) begin
            state_d = DEMAND;
            addr_d  = dAddr & BLK_MASK;
            dAck    = 1'b1;
          end else if (pReq) begin
            state_d = PREFETCH;
            addr_d  = pAddr & BLK_MASK;
            pAck    = 1'b1;
          end
        end
        DEMAND: begin
          if (memDataReady) begin
            dValid = 1'b1;
            cnt_d  = cnt_q + CW'(1);
          end
        end
        PREFETCH: begin
          if (memDataReady) begin
            pValid = 1'b1;
            dValid = merged_q;
            cnt_d  = cnt_q + CW'(1);
          end else if (dReq && !merged_q && (cnt_q == '0) &&
                       ((dAddr & BLK_MASK) == addr_q)) begin
            // Demand hits the block about to stream: ride along instead of queueing.
            merged_d = 1'b1;
            dAck     = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
      if (state_q != IDLE && last_word) begin
        dDone    = (state_q == DEMAND) || merged_q;
        pDone    = (state_q == PREFETCH);
        state_d  = IDLE;
        cnt_d    = '0;
        merged_d = 1'b0;
      end
    end
  end

endmodule

// File: doc/ucsbece154b_imem_arbiter.md
# ucsbece154b_imem_arbiter

Fixed-priority read arbiter sharing the single instruction-memory (SDRAM model) burst port between the icache demand-miss path and the instruction prefetcher. It sits between both requesters and the imem, sequences one block burst at a time, and routes the returned words to the owner. A demand miss to the same block as a not-yet-started prefetch burst merges into it instead of waiting.

## Interface
- `BLOCK_WORDS`, 4: words per burst; power of two, ≥2.
- `WORD_SIZE`, 32: data width.
- `OFF` (localparam) = log2(BLOCK_WORDS)+2: byte-offset bits cleared for block alignment.

- `clk` in 1: single clock; all state changes on rising edge.
- `reset` in 1: asynchronous, active-low reset (0 = reset).
- `dReq` in 1: demand request, level; held with stable `dAddr` until `dDone`.
- `dAddr` in 32: demand byte address.
- `dAck` out 1: pulse, demand request accepted (burst started or merged).
- `dValid` out 1: demand word valid this cycle.
- `dDone` out 1: pulse with last demand word.
- `pReq` in 1 / `pAddr` in 32 / `pAck`, `pValid`, `pDone` out 1: same semantics for prefetcher.
- `rdData` out WORD_SIZE: word to both requesters (passthrough of `memDataIn`).
- `rdIndex` out log2(BLOCK_WORDS): word index (passthrough of `memBlockIndex`).
- `memReadRequest` out 1: held high for whole burst.
- `memReadAddress` out 32: block-aligned burst address, stable while request high.
- `memDataIn` in WORD_SIZE, `memDataReady` in 1, `memBlockIndex` in log2(BLOCK_WORDS): one pulse per returned word.

## Operation
- States: IDLE, DEMAND, PREFETCH. Registers: state, `addrReg` (32), word counter `cnt` (log2(BLOCK_WORDS)+1 bits), `merged` flag.
- IDLE: `dReq`=1 → DEMAND, `addrReg`={dAddr[31:OFF],0}, `dAck` pulses this cycle. Else `pReq`=1 → PREFETCH, `addrReg` from `pAddr`, `pAck` pulses. Demand wins ties.
- `memReadRequest` = (state≠IDLE), registered; `memReadAddress`=`addrReg`.
- Each `memDataReady` while busy: `cnt`++; `dValid` = memDataReady & (DEMAND | merged); `pValid` = memDataReady & PREFETCH.
- Burst end: `memDataReady` with `cnt`=BLOCK_WORDS-1 → `*Done` pulse with that word (both `dDone` and `pDone` if merged), next state IDLE, `cnt`←0, `merged`←0.
- Merge: in PREFETCH, `dReq`=1, `merged`=0, block of `dAddr` equals `addrReg[31:OFF]`, `cnt`=0 and no `memDataReady` this cycle → `merged`←1, `dAck` pulses. Otherwise demand waits; it is taken first at the next IDLE.
- No preemption: a running prefetch burst always completes.
- `memDataReady` in IDLE ignored; no valid pulses.

## Timing
- Reset (async, `reset`=0): state IDLE, `cnt`=0, `merged`=0, `addrReg`=0; all outputs 0 (`rdData`/`rdIndex` follow inputs).
- `*Ack` combinational in the IDLE cycle where request is sampled; `memReadRequest` rises next cycle.
- `*Valid`, `*Done`, `rdData`, `rdIndex`: combinational, same cycle as `memDataReady`; zero added latency.
- After `*Done`, `memReadRequest` low for at least one cycle (IDLE). Requester must drop its request from the cycle after its `*Done`; arbiter does not re-sample it before.
- Back-to-back: demand pending during prefetch → `dAck` in the IDLE cycle immediately after `pDone`; memory request re-rises one cycle later.
- Reset mid-burst: immediate return to IDLE; partial data discarded, no `*Done`.
- Request dropped mid-burst (protocol violation): burst still completes; behavior is defined but the requester's data is unspecified.

## Test plan
- Reset: hold `reset`=0 with both reqs high → all outputs 0; release → `dAck` pulses, `memReadRequest`=1 next cycle.
- Demand only, `dAddr`=0x0000_0014, BLOCK_WORDS=4 → `memReadAddress`=0x0000_0010; 4 `dValid` pulses with indices 0..3, `dDone` on 4th; `memReadRequest` low the following cycle.
- Simultaneous `dReq`/`pReq` (0x100 / 0x200) → demand burst at 0x100 first, `pAck` in IDLE cycle after `dDone`, prefetch burst at 0x200.
- Merge: prefetch 0x300 started, `dReq` at 0x30C before first word → `dAck`, no new burst; each word raises `dValid` and `pValid`; `dDone` and `pDone` together.
- No-merge: same as above but `dReq` arrives after word 1 → waits; new demand burst at 0x300 after `pDone`.
- Reset asserted after 2 of 4 words → outputs 0 immediately, no `*Done`; fresh request afterwards completes normally.
